// File: rtl/stream_pkg.sv
// stream_pkg: shared FSM state type and default widths for the stream transmit path.
package stream_pkg;
   localparam int DATA_WIDTH_D  = 8;
   localparam int DEPTH_D       = 4;
   localparam int GAP_WIDTH_D   = 4;
   localparam int COUNT_WIDTH_D = 16;
   typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_e;
endpackage

// File: rtl/stream_source_tx_if.sv
// stream_source_tx_if: load port and outgoing valid/ready stream bundled for the transmitter.
interface stream_source_tx_if import stream_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_D);
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  stream_out_valid;
   logic [DATA_WIDTH-1:0] stream_out_data;
   logic                  stream_out_ready;
   modport master (input load_valid, load_data, stream_out_ready, output load_ready, stream_out_valid, stream_out_data);
   modport slave (output load_valid, load_data, stream_out_ready, input load_ready, stream_out_valid, stream_out_data);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: register-array FIFO with head data, full/empty flags and occupancy level.
module stream_fifo import stream_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int DEPTH      = DEPTH_D,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           level
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           level_q, level_d;
   assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
   assign head    = mem_q[rd_ptr_q];
   assign full    = level_q == (AW+1)'(DEPTH);
   assign empty   = level_q == '0;
   assign level   = level_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         level_q  <= level_d;
      end
   end
   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/stream_source_tx.sv
// stream_source_tx: buffers loaded beats and emits them on a valid/ready stream
// with an optional idle gap after each accepted beat, counting accepted beats.
module stream_source_tx import stream_pkg::*; #(
   parameter int DATA_WIDTH  = DATA_WIDTH_D,
   parameter int DEPTH       = DEPTH_D,
   parameter int GAP_WIDTH   = GAP_WIDTH_D,
   parameter int COUNT_WIDTH = COUNT_WIDTH_D,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   stream_source_tx_if.master     bus,
   input  logic [GAP_WIDTH-1:0]   gap_cycles,
   output logic [COUNT_WIDTH-1:0] sent_count,
   output logic                   idle
);
   tx_state_e             state_q, state_d;
   logic [GAP_WIDTH-1:0]  gap_q, gap_d;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                  push, pop, full, empty, more;
   logic [AW:0]           level, level_nxt;
   stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (bus.load_data),
      .head      (bus.stream_out_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );
   assign bus.load_ready       = !full;
   assign push                 = bus.load_valid && !full;
   assign bus.stream_out_valid = state_q == SEND;
   assign pop                  = bus.stream_out_valid && bus.stream_out_ready;
   // Decisions use the post-update level so a push is visible one cycle later.
   assign level_nxt            = level + (AW+1)'(push) - (AW+1)'(pop);
   assign more                 = level_nxt != '0;
   assign sent_count           = count_q;
   assign idle                 = state_q == IDLE && empty;
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: state_d = more ? SEND : IDLE;
         SEND: if (pop) begin
            gap_d   = gap_cycles;
            state_d = gap_cycles != '0 ? GAP : more ? SEND : IDLE;
         end
         GAP: begin
            gap_d   = gap_q - 1'b1;
            state_d = gap_q != GAP_WIDTH'(1) ? GAP : more ? SEND : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gap_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         count_q <= count_q + COUNT_WIDTH'(pop);
      end
   end
endmodule

// File: tb/tb_stream_source_tx.sv
// tb_stream_source_tx: directed and random stimulus checked cycle by cycle against
// a queue-based model of the buffered stream with idle gaps.
module tb_stream_source_tx;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  gap_cycles;
   logic [15:0] sent_count;
   logic        idle;
   int          vectors = 0;
   int          errors = 0;
   logic [7:0]  q[$];
   int          gap_left = 0;
   logic [15:0] cnt = '0;
   int          pushed_total = 0;
   int          sent_total = 0;

   stream_source_tx_if #(.DATA_WIDTH(8)) bus ();

   stream_source_tx dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .gap_cycles (gap_cycles),
      .sent_count (sent_count),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      bus.load_valid = 1'b0;
      bus.load_data = '0;
      bus.stream_out_ready = 1'b0;
      gap_cycles = '0;
      reset_n = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.stream_out_valid), 0);
      chk("rst_load_ready", 32'(bus.load_ready), 1);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_count", 32'(sent_count), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      gap_left = 0;
      cnt = '0;
      pushed_total = 0;
      sent_total = 0;
   endtask

   // One clock: drive inputs, check outputs against the model, then advance the model.
   task automatic cyc(input logic lv, input logic [7:0] ld, input logic rdy, input logic [3:0] g);
      logic ev, hs, push;
      bus.load_valid = lv;
      bus.load_data = ld;
      bus.stream_out_ready = rdy;
      gap_cycles = g;
      #1;
      ev = q.size() != 0 && gap_left == 0;
      chk("valid", 32'(bus.stream_out_valid), 32'(ev));
      chk("load_ready", 32'(bus.load_ready), 32'(q.size() < 4));
      chk("idle", 32'(idle), 32'(q.size() == 0 && gap_left == 0));
      chk("sent_count", 32'(sent_count), 32'(cnt));
      if (ev) chk("data", 32'(bus.stream_out_data), 32'(q[0]));
      hs = ev && rdy;
      push = lv && q.size() < 4;
      @(posedge clk);
      if (hs) begin
         void'(q.pop_front());
         cnt = cnt + 16'd1;
         sent_total++;
         gap_left = int'(g);
      end else if (gap_left > 0) gap_left--;
      if (push) begin
         q.push_back(ld);
         pushed_total++;
      end
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data = '0;
      bus.stream_out_ready = 1'b0;
      gap_cycles = '0;
      #2;
      do_reset();
      // back-to-back beats with ready tied high
      cyc(1, 8'h11, 1, 0);
      cyc(1, 8'h22, 1, 0);
      cyc(1, 8'h33, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
      chk("b2b_count", 32'(sent_count), 3);
      // backpressure holds the head beat
      cyc(1, 8'h11, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      chk("bp_count", 32'(sent_count), 4);
      // fill the FIFO, refuse a fifth beat, then pop one
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
      cyc(1, 8'hEE, 0, 0);
      cyc(1, 8'hEF, 1, 0);
      cyc(0, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0);
      chk("full_count", 32'(sent_count), 8);
      // idle gap of three cycles between two beats
      cyc(1, 8'h55, 1, 3);
      cyc(1, 8'h66, 1, 3);
      for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 3);
      chk("gap_idle", 32'(idle), 1);
      // reset in the middle of a held transfer
      cyc(1, 8'h77, 0, 0);
      cyc(0, 8'h00, 0, 0);
      do_reset();
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      // random traffic
      for (int i = 0; i < 600; i++)
         cyc(1'($urandom_range(3) != 0), 8'($urandom_range(255)), 1'($urandom_range(3) != 0),
             ($urandom_range(2) == 0) ? 4'($urandom_range(3)) : 4'd0);
      for (int i = 0; i < 40; i++) cyc(0, 8'h00, 1, 0);
      chk("rand_drained", 32'(idle), 1);
      // counter wrap after 2^16 accepted beats
      do_reset();
      for (int i = 0; i < 70000 && sent_total < 65536; i++)
         cyc(pushed_total < 65536, 8'(i), 1, 0);
      chk("wrap_budget", 32'(sent_total), 65536);
      chk("wrap_count", 32'(sent_count), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
